// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, ALU commands and condition codes.
package arm_ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
      EXECR, EXECI, ALUWB, BRANCH, UNKNOWN
   } state_t;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALU    = 2'b10;

   localparam logic [1:0] SRCB_REG  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_TST = 4'b1000;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;
   localparam logic [3:0] CMD_LSL = 4'b1101;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

endpackage

// File: rtl/alu_decoder.sv
// ALU field decode for data-processing instructions.
// MAIN_FSM_SHIFT_EN adds cmd 1101 (LSL) driving the shifter select.
module alu_decoder
   import arm_ctrl_pkg::*;
(
   input  logic       alu_op,
   input  logic [4:0] funct,
   output logic [1:0] alu_ctl,
   output logic [1:0] flag_w,
   output logic       no_write,
   output logic       shift
);

   logic [3:0] cmd;
   logic       s;

   assign cmd = funct[4:1];
   assign s   = funct[0];

   always_comb begin
      alu_ctl  = ALU_ADD;
      flag_w   = 2'b00;
      no_write = 1'b0;
      shift    = 1'b0;
      if (alu_op) begin
         case (cmd)
            CMD_ADD: begin alu_ctl = ALU_ADD; flag_w = {s, s};    end
            CMD_SUB: begin alu_ctl = ALU_SUB; flag_w = {s, s};    end
            CMD_AND: begin alu_ctl = ALU_AND; flag_w = {s, 1'b0}; end
            CMD_ORR: begin alu_ctl = ALU_ORR; flag_w = {s, 1'b0}; end
            CMD_CMP: begin alu_ctl = ALU_SUB; flag_w = {s, s};    no_write = 1'b1; end
            CMD_TST: begin alu_ctl = ALU_AND; flag_w = {s, 1'b0}; no_write = 1'b1; end
`ifdef MAIN_FSM_SHIFT_EN
            CMD_LSL: begin alu_ctl = ALU_ADD; flag_w = {s, 1'b0}; shift = 1'b1; end
`endif
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/cond_logic.sv
// NZCV flag registers, condition evaluation and the registered condition
// result used to gate architectural writes one cycle later.
module cond_logic
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [3:0] alu_flags,
   input  logic [1:0] flag_w,
   output logic       cond_ex_q
);

   logic [3:0] flags;
   logic       cond_ex;
   logic       n, z, c, v;

   assign {n, z, c, v} = flags;

   always_comb begin
      cond_ex = 1'b0;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         COND_AL: cond_ex = 1'b1;
         default: cond_ex = 1'b0;
      endcase
   end

   // Flag writes use the live condition so a predicated compare only
   // updates flags when it would have executed.
   always_ff @(posedge clk) begin
      if (reset) begin
         flags     <= 4'b0000;
         cond_ex_q <= 1'b0;
      end else begin
         if (flag_w[1] & cond_ex) flags[3:2] <= alu_flags[3:2];
         if (flag_w[0] & cond_ex) flags[1:0] <= alu_flags[1:0];
         cond_ex_q <= cond_ex;
      end
   end

endmodule

// File: rtl/main_fsm.sv
// Multicycle ARM control unit: Moore FSM sequencing the shared datapath.
// Optional LSL decode is enabled with MAIN_FSM_SHIFT_EN.
module main_fsm
   import arm_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] cond,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic [3:0] rd,
   input  logic [3:0] alu_flags,
   output logic       pc_write,
   output logic       adr_src,
   output logic       mem_write,
   output logic       ir_write,
   output logic       reg_write,
   output logic [1:0] result_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] imm_src,
   output logic [1:0] reg_src,
   output logic [1:0] alu_ctl,
   output logic       shift
);

   state_t     state_q, state_nx, out_state;
   logic       next_pc, reg_w, mem_w, branch, alu_op, ir_w;
   logic [1:0] flag_w;
   logic       no_write;
   logic       cond_ex_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= FETCH;
      else       state_q <= state_nx;
   end

   always_comb begin
      state_nx = FETCH;
      case (state_q)
         FETCH:  state_nx = DECODE;
         DECODE: begin
            case (op)
               2'b00:   state_nx = funct[5] ? EXECI : EXECR;
               2'b01:   state_nx = MEMADR;
               2'b10:   state_nx = BRANCH;
               default: state_nx = UNKNOWN;
            endcase
         end
         MEMADR: state_nx = funct[0] ? MEMRD : MEMWR;
         MEMRD:  state_nx = MEMWB;
         EXECR:  state_nx = ALUWB;
         EXECI:  state_nx = ALUWB;
         default: state_nx = FETCH;
      endcase
   end

   // Selects show FETCH values while reset is held, whatever state_q holds.
   assign out_state = reset ? FETCH : state_q;

   always_comb begin
      next_pc    = 1'b0;
      reg_w      = 1'b0;
      mem_w      = 1'b0;
      branch     = 1'b0;
      alu_op     = 1'b0;
      ir_w       = 1'b0;
      adr_src    = 1'b0;
      result_src = RES_ALUOUT;
      alu_src_a  = 1'b0;
      alu_src_b  = SRCB_REG;
      case (out_state)
         FETCH: begin
            ir_w = 1'b1; next_pc = 1'b1; alu_src_a = 1'b1;
            alu_src_b = SRCB_FOUR; result_src = RES_ALU;
         end
         DECODE: begin
            alu_src_a = 1'b1; alu_src_b = SRCB_FOUR; result_src = RES_ALU;
         end
         MEMADR: alu_src_b = SRCB_IMM;
         MEMRD:  adr_src = 1'b1;
         MEMWB:  begin result_src = RES_DATA; reg_w = 1'b1; end
         MEMWR:  begin adr_src = 1'b1; mem_w = 1'b1; end
         EXECR:  alu_op = 1'b1;
         EXECI:  begin alu_op = 1'b1; alu_src_b = SRCB_IMM; end
         ALUWB:  reg_w = 1'b1;
         BRANCH: begin alu_src_b = SRCB_IMM; result_src = RES_ALU; branch = 1'b1; end
         default: ;
      endcase
   end

   alu_decoder u_alu_dec (
      .alu_op   (alu_op),
      .funct    (funct[4:0]),
      .alu_ctl  (alu_ctl),
      .flag_w   (flag_w),
      .no_write (no_write),
      .shift    (shift)
   );

   cond_logic u_cond (
      .clk       (clk),
      .reset     (reset),
      .cond      (cond),
      .alu_flags (alu_flags),
      .flag_w    (flag_w),
      .cond_ex_q (cond_ex_q)
   );

   assign imm_src   = op;
   assign reg_src   = {op == 2'b01, op == 2'b10};
   assign ir_write  = ir_w & ~reset;
   assign reg_write = ~reset & reg_w & cond_ex_q & ~no_write;
   assign mem_write = ~reset & mem_w & cond_ex_q;
   assign pc_write  = ~reset & (next_pc |
                      (cond_ex_q & (branch | (reg_w & (rd == 4'd15) & ~no_write))));

endmodule

// File: tb/tb_main_fsm.sv
// Self-checking bench for main_fsm: a cycle model pushes expected output
// vectors per instruction; a negedge monitor pops and compares them.
module tb_main_fsm;

   localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                  S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                  S_UNKNOWN = 10;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic [3:0] alu_flags;
   logic       pc_write, adr_src, mem_write, ir_write, reg_write, alu_src_a, shift;
   logic [1:0] result_src, alu_src_b, imm_src, reg_src, alu_ctl;

   int n_vec  = 0;
   int n_fail = 0;

   logic [16:0] exp_q[$];
   logic [16:0] obs[5];
   logic [3:0]  m_flags;
   logic        m_cq;

   main_fsm dut (
      .clk(clk), .reset(reset), .cond(cond), .op(op), .funct(funct), .rd(rd),
      .alu_flags(alu_flags), .pc_write(pc_write), .adr_src(adr_src),
      .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
      .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .imm_src(imm_src), .reg_src(reg_src), .alu_ctl(alu_ctl), .shift(shift)
   );

   always #5 clk = ~clk;

   // Vector layout: pcw[16] adr[15] memw[14] irw[13] regw[12] res[11:10]
   // srca[9] srcb[8:7] imm[6:5] regsrc[4:3] aluctl[2:1] shift[0]
   function automatic logic [16:0] actual_vec();
      return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
              alu_src_a, alu_src_b, imm_src, reg_src, alu_ctl, shift};
   endfunction

   function automatic logic [16:0] reset_vec();
      return {5'b00000, 2'b10, 1'b1, 2'b10, op, op == 2'b01, op == 2'b10, 2'b00, 1'b0};
   endfunction

   function automatic logic cond_ok(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_cycle(input int st);
      logic       npc = 0, rw = 0, mw = 0, br = 0, aop = 0, irw = 0, adr = 0, sa = 0;
      logic [1:0] res = 2'b00, sb = 2'b00, actl = 2'b00, fw = 2'b00;
      logic       nw = 0, sh = 0, ce, s;
      logic       pcw, regw, memw;
      case (st)
         S_FETCH:  begin irw = 1; npc = 1; sa = 1; sb = 2'b10; res = 2'b10; end
         S_DECODE: begin sa = 1; sb = 2'b10; res = 2'b10; end
         S_MEMADR: sb = 2'b01;
         S_MEMRD:  adr = 1;
         S_MEMWB:  begin res = 2'b01; rw = 1; end
         S_MEMWR:  begin adr = 1; mw = 1; end
         S_EXECR:  aop = 1;
         S_EXECI:  begin aop = 1; sb = 2'b01; end
         S_ALUWB:  rw = 1;
         S_BRANCH: begin sb = 2'b01; res = 2'b10; br = 1; end
         default: ;
      endcase
      s = funct[0];
      if (aop) begin
         case (funct[4:1])
            4'b0100: begin actl = 2'b00; fw = {s, s}; end
            4'b0010: begin actl = 2'b01; fw = {s, s}; end
            4'b0000: begin actl = 2'b10; fw = {s, 1'b0}; end
            4'b1100: begin actl = 2'b11; fw = {s, 1'b0}; end
            4'b1010: begin actl = 2'b01; fw = {s, s}; nw = 1; end
            4'b1000: begin actl = 2'b10; fw = {s, 1'b0}; nw = 1; end
`ifdef MAIN_FSM_SHIFT_EN
            4'b1101: begin actl = 2'b00; fw = {s, 1'b0}; sh = 1; end
`endif
            default: ;
         endcase
      end
      regw = rw & m_cq & !nw;
      memw = mw & m_cq;
      pcw  = npc | (m_cq & (br | (rw & (rd == 4'd15) & !nw)));
      exp_q.push_back({pcw, adr, memw, irw, regw, res, sa, sb, op,
                       op == 2'b01, op == 2'b10, actl, sh});
      ce = cond_ok(cond, m_flags);
      if (fw[1] && ce) m_flags[3:2] = alu_flags[3:2];
      if (fw[0] && ce) m_flags[1:0] = alu_flags[1:0];
      m_cq = ce;
   endtask

   // Drives one instruction from its FETCH negedge; records each cycle's outputs.
   task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                            input logic [3:0] r, input logic [3:0] af, input int limit,
                            output int n);
      int seq[5];
      int len;
      cond = c; op = o; funct = f; rd = r; alu_flags = af;
      seq[0] = S_FETCH; seq[1] = S_DECODE;
      seq[2] = S_UNKNOWN; seq[3] = S_FETCH; seq[4] = S_FETCH;
      case (o)
         2'b00: begin seq[2] = f[5] ? S_EXECI : S_EXECR; seq[3] = S_ALUWB; len = 4; end
         2'b01: begin
            seq[2] = S_MEMADR;
            if (f[0]) begin seq[3] = S_MEMRD; seq[4] = S_MEMWB; len = 5; end
            else      begin seq[3] = S_MEMWR; len = 4; end
         end
         2'b10:   begin seq[2] = S_BRANCH; len = 3; end
         default: begin seq[2] = S_UNKNOWN; len = 3; end
      endcase
      n = (len < limit) ? len : limit;
      for (int i = 0; i < n; i++) model_cycle(seq[i]);
      for (int i = 0; i < n; i++) begin
         #2 obs[i] = actual_vec();
         @(negedge clk);
      end
   endtask

   always @(negedge clk) begin
      logic [16:0] e, a;
      #1;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         a = actual_vec();
         n_vec++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL scoreboard @%0t: got %b expected %b", $time, a, e);
         end
      end
   end

   task automatic test_reset();
      logic [16:0] a;
      reset = 1'b1; cond = 4'hE; op = 2'b01; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
      repeat (3) @(negedge clk);
      #2 a = actual_vec();
      n_vec++;
      if (a !== reset_vec()) begin
         n_fail++; $display("FAIL reset_hold: got %b expected %b", a, reset_vec());
      end
      op = 2'b10;
      #1 a = actual_vec();
      n_vec++;
      if (a !== reset_vec()) begin
         n_fail++; $display("FAIL reset_hold_op10: got %b expected %b", a, reset_vec());
      end
      @(negedge clk);
      reset = 1'b0;
      m_flags = 4'b0000; m_cq = 1'b0;
   endtask

   task automatic test_first_fetch();
      int n;
      run_instr(4'hE, 2'b00, 6'b001000, 4'd1, 4'b0000, 5, n);
      n_vec++;
      if (obs[0][16] !== 1'b1 || obs[0][13] !== 1'b1 || obs[0][8:7] !== 2'b10) begin
         n_fail++; $display("FAIL first_fetch: got %b expected pcw=1 irw=1 srcb=10", obs[0]);
      end
      n_vec++;
      if (obs[1][16:12] !== 5'b00000) begin
         n_fail++; $display("FAIL decode_enables: got %b expected 00000", obs[1][16:12]);
      end
   endtask

   task automatic test_add();
      int n;
      run_instr(4'hE, 2'b00, 6'b001001, 4'd3, 4'b0100, 5, n);
      n_vec++;
      if (n !== 4 || obs[2][2:1] !== 2'b00 || obs[3][12] !== 1'b1) begin
         n_fail++; $display("FAIL add: got cycles=%0d aluctl=%b regw=%b expected 4 00 1",
                            n, obs[2][2:1], obs[3][12]);
      end
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 5, n);
      n_vec++;
      if (obs[2][16] !== 1'b1) begin
         n_fail++; $display("FAIL add_sets_z: BEQ pcw got %b expected 1", obs[2][16]);
      end
   endtask

   task automatic test_branch();
      int n;
      run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 5, n);
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 5, n);
      n_vec++;
      if (n !== 3 || obs[2][16] !== 1'b1) begin
         n_fail++; $display("FAIL beq_taken: got cycles=%0d pcw=%b expected 3 1", n, obs[2][16]);
      end
      run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0000, 5, n);
      run_instr(4'h0, 2'b10, 6'b000000, 4'd0, 4'b0000, 5, n);
      n_vec++;
      if (obs[2][16] !== 1'b0) begin
         n_fail++; $display("FAIL beq_not_taken: pcw got %b expected 0", obs[2][16]);
      end
   endtask

   task automatic test_ldr();
      int n;
      run_instr(4'hE, 2'b01, 6'b000001, 4'd2, 4'b0000, 5, n);
      n_vec++;
      if (n !== 5 || obs[3][15] !== 1'b1 || obs[4][11:10] !== 2'b01 || obs[4][12] !== 1'b1) begin
         n_fail++; $display("FAIL ldr: got cycles=%0d adr=%b res=%b regw=%b expected 5 1 01 1",
                            n, obs[3][15], obs[4][11:10], obs[4][12]);
      end
   endtask

   task automatic test_str_ne();
      int n;
      run_instr(4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100, 5, n);
      run_instr(4'h1, 2'b01, 6'b000000, 4'd4, 4'b0000, 5, n);
      n_vec++;
      if (n !== 4 || obs[3][14] !== 1'b0) begin
         n_fail++; $display("FAIL str_ne: got cycles=%0d memw=%b expected 4 0", n, obs[3][14]);
      end
      run_instr(4'hE, 2'b01, 6'b000000, 4'd4, 4'b0000, 5, n);
      n_vec++;
      if (obs[3][14] !== 1'b1) begin
         n_fail++; $display("FAIL str_al: memw got %b expected 1", obs[3][14]);
      end
   endtask

   task automatic test_pc_dest();
      int n;
      run_instr(4'hE, 2'b00, 6'b001000, 4'd15, 4'b0000, 5, n);
      n_vec++;
      if (obs[3][16] !== 1'b1 || obs[3][12] !== 1'b1) begin
         n_fail++; $display("FAIL rd15: got pcw=%b regw=%b expected 1 1", obs[3][16], obs[3][12]);
      end
   endtask

   task automatic test_reset_mid();
      int n;
      logic [16:0] a;
      run_instr(4'hE, 2'b01, 6'b000001, 4'd5, 4'b0000, 3, n);
      #2 a = actual_vec();
      n_vec++;
      if (a[15] !== 1'b1 || a[12] !== 1'b0) begin
         n_fail++; $display("FAIL memrd_before_reset: got adr=%b regw=%b expected 1 0", a[15], a[12]);
      end
      reset = 1'b1;
      #1 a = actual_vec();
      n_vec++;
      if (a !== reset_vec()) begin
         n_fail++; $display("FAIL reset_in_memrd: got %b expected %b", a, reset_vec());
      end
      @(negedge clk);
      #2 a = actual_vec();
      n_vec++;
      if (a !== reset_vec()) begin
         n_fail++; $display("FAIL reset_after_memrd: got %b expected %b", a, reset_vec());
      end
      @(negedge clk);
      reset = 1'b0;
      m_flags = 4'b0000; m_cq = 1'b0;
      run_instr(4'hE, 2'b00, 6'b001000, 4'd6, 4'b0000, 5, n);
      n_vec++;
      if (obs[0][13] !== 1'b1 || obs[0][12] !== 1'b0) begin
         n_fail++; $display("FAIL fetch_after_reset: got irw=%b regw=%b expected 1 0",
                            obs[0][13], obs[0][12]);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      logic [3:0] cmds[8];
      logic [3:0] c, r;
      logic [5:0] f;
      cmds = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b1000, 4'b1101, 4'b0111};
      for (int i = 0; i < 60; i++) begin
         c = 4'($urandom_range(0, 15));
         f = {1'($urandom_range(0, 1)), cmds[$urandom_range(0, 7)], 1'($urandom_range(0, 1))};
         r = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
         run_instr(c, 2'($urandom_range(0, 3)), f, r, 4'($urandom_range(0, 15)), 5, n);
      end
   endtask

   initial begin
      m_flags = 4'b0000;
      m_cq    = 1'b0;
      test_reset();
      test_first_fetch();
      test_add();
      test_branch();
      test_ldr();
      test_str_ne();
      test_pc_dest();
      test_reset_mid();
      test_back_to_back();
      @(negedge clk);
      #3;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
